// File: rtl/saber_ins_pkg.sv
// Shared constants for the Saber instruction sequencer: word layout, opcodes, FSM encodings.
package saber_ins_pkg;

  localparam int ADDR_W     = 6;
  localparam int INS_W      = 37;
  localparam int START_ADDR = 0;

  localparam int INS_LSB    = 0;
  localparam int OP1_LSB    = 5;
  localparam int OP2_LSB    = 15;
  localparam int OP3_LSB    = 25;
  localparam int WE0_BIT    = 35;
  localparam int WE1_BIT    = 36;
  localparam int IMM_LO_LSB = 0;
  localparam int IMM_HI_LSB = 16;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LOOP = 5'd30;
  localparam logic [4:0] OP_END  = 5'd31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic        we1;
    logic        we0;
    logic [9:0]  op3;
    logic [9:0]  op2;
    logic [9:0]  op1;
    logic [4:0]  ins_code;
    logic [15:0] imm_hi;
    logic [15:0] imm_lo;
  } ins_fields_t;

endpackage

// File: rtl/ins_sequencer_if.sv
// Issue bus between the sequencer (master) and the arithmetic datapath (slave).
interface ins_sequencer_if;

  logic        ins_valid;
  logic        ins_ready;
  logic [4:0]  ins_code;
  logic [9:0]  op1;
  logic [9:0]  op2;
  logic [9:0]  op3;
  logic [15:0] imm_hi;
  logic [15:0] imm_lo;
  logic        we0;
  logic        we1;

  modport master (
    output ins_valid, ins_code, op1, op2, op3, imm_hi, imm_lo, we0, we1,
    input  ins_ready
  );

  modport slave (
    input  ins_valid, ins_code, op1, op2, op3, imm_hi, imm_lo, we0, we1,
    output ins_ready
  );

endinterface

// File: rtl/ins_sequencer_field_decode.sv
// Purely combinational split of a 37-bit ROM word into its datapath fields.
module ins_field_decode
  import saber_ins_pkg::*;
(
  input  logic [INS_W-1:0] rom_data,
  output ins_fields_t      fields
);

  assign fields.we1      = rom_data[WE1_BIT];
  assign fields.we0      = rom_data[WE0_BIT];
  assign fields.op3      = rom_data[OP3_LSB +: 10];
  assign fields.op2      = rom_data[OP2_LSB +: 10];
  assign fields.op1      = rom_data[OP1_LSB +: 10];
  assign fields.ins_code = rom_data[INS_LSB +: 5];
  assign fields.imm_hi   = rom_data[IMM_HI_LSB +: 16];
  assign fields.imm_lo   = rom_data[IMM_LO_LSB +: 16];

endmodule

// File: rtl/ins_sequencer.sv
// PC and fetch/decode/issue controller for the Saber instruction ROM.
// Optional hardware loop support is enabled by defining SEQ_LOOP_EN.
module ins_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [saber_ins_pkg::INS_W-1:0] rom_data,
  ins_sequencer_if.master                ins,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  import saber_ins_pkg::*;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  ins_fields_t       dec;
  ins_fields_t       fld;
  logic              is_nop;
  logic              is_end;
  logic              is_loop;
  logic              loop_take;
  logic [ADDR_W-1:0] loop_target;

  ins_field_decode u_field_decode (
    .rom_data (rom_data),
    .fields   (dec)
  );

  // A we1 word carries a 32-bit immediate over the opcode bits, so it is always issued.
  assign is_nop      = !dec.we1 && (dec.ins_code == OP_NOP);
  assign is_end      = !dec.we1 && (dec.ins_code == OP_END);
  assign loop_target = dec.op1[ADDR_W-1:0];

`ifdef SEQ_LOOP_EN
  logic [9:0]        loop_cnt;
  logic [ADDR_W-1:0] loop_pc;
  logic              loop_act;
  logic [9:0]        loop_eff;

  // A LOOP word at a different address than the tracked one restarts the counter.
  assign is_loop   = !dec.we1 && (dec.ins_code == OP_LOOP);
  assign loop_eff  = (loop_act && (loop_pc == pc)) ? loop_cnt : dec.op2;
  assign loop_take = is_loop && (loop_eff > 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_cnt <= '0;
      loop_pc  <= '0;
      loop_act <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      loop_cnt <= '0;
      loop_act <= 1'b0;
    end else if (state == ST_DECODE && is_loop) begin
      if (loop_take) begin
        loop_cnt <= loop_eff - 10'd1;
        loop_pc  <= pc;
        loop_act <= 1'b1;
      end else begin
        loop_cnt <= '0;
        loop_act <= 1'b0;
      end
    end
  end
`else
  assign is_loop   = 1'b0;
  assign loop_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= START_PC;
      err           <= 1'b0;
      ins.ins_valid <= 1'b0;
      fld           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= START_PC;
            err   <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (is_end) begin
            state <= ST_DONE;
          end else if (loop_take) begin
            pc    <= loop_target;
            state <= ST_FETCH;
          end else if (is_nop || is_loop) begin
            if (&pc) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            fld           <= dec;
            ins.ins_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The PC does not wrap: stepping past the last address is a program error.
          if (ins.ins_ready) begin
            ins.ins_valid <= 1'b0;
            if (&pc) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr     = pc;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign ins.ins_code = fld.ins_code;
  assign ins.op1      = fld.op1;
  assign ins.op2      = fld.op2;
  assign ins.op3      = fld.op3;
  assign ins.imm_hi   = fld.imm_hi;
  assign ins.imm_lo   = fld.imm_lo;
  assign ins.we0      = fld.we0;
  assign ins.we1      = fld.we1;

endmodule

// File: tb/tb_ins_sequencer.sv
// Self-checking bench for ins_sequencer: directed programs plus randomized ROMs against an instruction-level model.
module tb_ins_sequencer;

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [36:0] rom_data;
  logic        busy;
  logic        done;
  logic        err;

  ins_sequencer_if bus ();

  ins_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ins      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  logic [36:0] rom [64];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  int          errors = 0;
  int          checks = 0;
  logic [36:0] exp_q [$];
  int          exp_total;
  bit          exp_err;

  function automatic logic [36:0] make_word(input logic we1, input logic we0, input logic [9:0] op3,
                                            input logic [9:0] op2, input logic [9:0] op1, input logic [4:0] code);
    return {we1, we0, op3, op2, op1, code};
  endfunction

  function automatic logic [36:0] make_imm(input logic [15:0] hi, input logic [15:0] lo);
    return {1'b1, 4'b0000, hi, lo};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fill_rom_end();
    for (int i = 0; i < 64; i++) rom[i] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd31);
  endtask

  task automatic load_case1();
    fill_rom_end();
    rom[0] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd0);
    rom[1] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd0);
    rom[2] = make_imm(16'd32, 16'd32);
    rom[3] = make_word(1'b0, 1'b0, 10'd124, 10'd0, 10'd124, 5'd1);
    rom[4] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd0);
    rom[5] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd31);
  endtask

  // Walks the program one instruction at a time and records what must be issued and how it ends.
  task automatic build_expected();
    int          pc;
    int          cnt;
    int          lpc;
    int          n;
    logic [36:0] w;
    bit          ended;
    exp_q.delete();
    exp_err = 1'b0;
    pc = 0; cnt = 0; lpc = -1; ended = 1'b0;
    for (int step = 0; step < 5000 && !ended; step++) begin
      w = rom[pc];
      if (!w[36] && w[4:0] == 5'd31) begin
        ended = 1'b1;
      end else if (LOOP_EN && !w[36] && w[4:0] == 5'd30) begin
        n = (lpc == pc) ? cnt : int'(w[24:15]);
        if (n > 1) begin
          cnt = n - 1;
          lpc = pc;
          pc  = int'(w[10:5]);
        end else begin
          cnt = 0;
          lpc = -1;
          if (pc == 63) begin exp_err = 1'b1; ended = 1'b1; end
          else pc++;
        end
      end else begin
        if (w[36] || w[4:0] != 5'd0) exp_q.push_back(w);
        if (pc == 63) begin exp_err = 1'b1; ended = 1'b1; end
        else pc++;
      end
    end
    exp_total = exp_q.size();
  endtask

  // ready_mode: 0 always ready, 1 random, 2 ready low for 5 cycles on the second issue.
  task automatic run_program(input string name, input int ready_mode, input bit poke_start);
    logic [36:0] cur_f;
    logic [36:0] prev_f;
    logic [31:0] w_imm;
    logic [36:0] w;
    bit          prev_stall;
    bit          done_prev;
    bit          finished;
    bit          r;
    int          issues;
    int          dones;
    int          hold;
    int          first_valid;
    bit          first_issuable;
    build_expected();
    first_issuable = rom[0][36] || (rom[0][4:0] != 5'd0 && rom[0][4:0] != 5'd31 &&
                     !(LOOP_EN && rom[0][4:0] == 5'd30));
    prev_stall = 1'b0; done_prev = 1'b0; finished = 1'b0;
    issues = 0; dones = 0; hold = 0; first_valid = -1; prev_f = '0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      cur_f = {bus.we1, bus.we0, bus.op3, bus.op2, bus.op1, bus.ins_code};
      if (cyc == 1) check({name, "_err_clear_on_start"}, err, 1'b0);
      if (bus.ins_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check({name, "_stall_valid"}, bus.ins_valid, 1'b1);
        check({name, "_stall_fields"}, cur_f, prev_f);
      end
      if (done_prev) begin
        check({name, "_busy_after_done"}, busy, 1'b0);
        done_prev = 1'b0;
      end
      if (done) begin
        dones++;
        done_prev = 1'b1;
      end
      if (!busy && !done_prev) finished = 1'b1;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          r = 1'b1;
          if (bus.ins_valid && issues == 1 && hold < 5) begin
            r = 1'b0;
            hold++;
          end
        end
      endcase
      bus.ins_ready = r;
      if (poke_start && busy && !done && $urandom_range(0, 5) == 0) start = 1'b1;
      if (bus.ins_valid && r) begin
        if (exp_q.size() > 0) begin
          w     = exp_q.pop_front();
          w_imm = w[31:0];
          check({name, "_issue_fields"}, cur_f, w);
          check({name, "_issue_imm"}, {bus.imm_hi, bus.imm_lo}, w_imm);
        end
        issues++;
      end
      prev_stall = bus.ins_valid && !r;
      prev_f     = cur_f;
    end
    start = 1'b0;
    bus.ins_ready = 1'b0;
    check({name, "_finished"}, finished, 1'b1);
    check({name, "_issue_count"}, issues, exp_total);
    check({name, "_done_count"}, dones, exp_err ? 0 : 1);
    check({name, "_err"}, err, exp_err);
    if (ready_mode == 2) check({name, "_hold_cycles"}, hold, 5);
    if (first_issuable && exp_total > 0 && ready_mode == 0) check({name, "_latency"}, first_valid, 3);
  endtask

  initial begin
    int seen;
    bus.ins_ready = 1'b0;
    fill_rom_end();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_rom_addr", rom_addr, 6'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", bus.ins_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic program, always ready
    load_case1();
    run_program("case1", 0, 1'b0);

    // Back-pressure on the second issue
    load_case1();
    run_program("case2", 2, 1'b0);

    // No END: PC runs off the top of the ROM
    fill_rom_end();
    for (int i = 0; i < 64; i++) rom[i] = make_word(1'b0, 1'b0, 10'(i), 10'(3 * i), 10'(i + 1), 5'd2);
    run_program("overflow", 0, 1'b0);
    load_case1();
    run_program("restart", 0, 1'b0);

    // Spurious start pulses while busy
    load_case1();
    run_program("start_poke", 1, 1'b1);

    // Loop program
    fill_rom_end();
    rom[0] = make_word(1'b0, 1'b0, 10'd7, 10'd8, 10'd9, 5'd2);
    rom[1] = make_word(1'b0, 1'b0, 10'd0, 10'd3, 10'd0, 5'd30);
    rom[2] = make_word(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 5'd31);
    run_program("loop", 0, 1'b0);

    // Randomized programs without LOOP words
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) begin
        logic [36:0] w;
        logic [4:0]  code;
        w    = {5'($urandom), $urandom};
        code = 5'($urandom_range(1, 29));
        case ($urandom_range(0, 9))
          0, 1:    code = 5'd0;
          2:       code = (i > 8) ? 5'd31 : 5'd3;
          default: ;
        endcase
        w[36]  = ($urandom_range(0, 5) == 0);
        if (!w[36]) w[4:0] = code;
        if (w[36] && w[4:0] == 5'd31) w[4:0] = 5'd4;
        rom[i] = w;
      end
      run_program("random", 1, 1'b1);
    end

    // Reset while an instruction is waiting in ISSUE
    load_case1();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !bus.ins_valid; i++) @(negedge clk);
    check("rst_reached_issue", bus.ins_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.ins_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rom_addr", rom_addr, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ins_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ins_valid || busy) seen++;
    end
    check("rst_no_issue_until_start", seen, 0);
    bus.ins_ready = 1'b0;
    run_program("after_reset", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
